// File: rtl/csr_pkg.sv
// Shared CSR encodings, trap-controller state and the fixed interrupt priority table.
package csr_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS = 12'h300,
    CSR_MIE     = 12'h304,
    CSR_MTVEC   = 12'h305,
    CSR_MEPC    = 12'h341,
    CSR_MCAUSE  = 12'h342,
    CSR_MTVAL   = 12'h343,
    CSR_MIP     = 12'h344
  } csr_addrs_e;

  typedef enum logic [4:0] {
    CAUSE_INSTR_MISALIGNED = 5'd0,
    CAUSE_INSTR_ACCESS     = 5'd1,
    CAUSE_ILLEGAL_INST     = 5'd2,
    CAUSE_BREAKPOINT       = 5'd3,
    CAUSE_LOAD_MISALIGNED  = 5'd4,
    CAUSE_LOAD_ACCESS      = 5'd5,
    CAUSE_STORE_MISALIGNED = 5'd6,
    CAUSE_STORE_ACCESS     = 5'd7,
    CAUSE_ECALL_U          = 5'd8,
    CAUSE_ECALL_S          = 5'd9,
    CAUSE_ECALL_M          = 5'd11,
    CAUSE_INSTR_PAGE_FAULT = 5'd12,
    CAUSE_LOAD_PAGE_FAULT  = 5'd13,
    CAUSE_STORE_PAGE_FAULT = 5'd15
  } csr_mcause_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_RETURN,
    ST_REDIRECT
  } trap_state_e;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // Highest priority first: MEI, MSI, MTI, SEI, SSI, STI, LCOFI.
  localparam int IRQ_PRIO_N = 7;
  localparam logic [3:0] IRQ_PRIO [IRQ_PRIO_N] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5, 4'd13};

endpackage

// File: rtl/trap_irq_prio.sv
// Fixed-priority encoder from the enabled pending-interrupt mask to an mcause code.
module trap_irq_prio
  import csr_pkg::*;
(
  input  logic [15:0] i_pending,
  output logic        o_valid,
  output logic [3:0]  o_code
);

  // Walk lowest priority to highest so the highest pending source is written last.
  always_comb begin
    o_valid = 1'b0;
    o_code  = 4'd0;
    for (int i = IRQ_PRIO_N - 1; i >= 0; i--) begin
      if (i_pending[IRQ_PRIO[i]]) begin
        o_valid = 1'b1;
        o_code  = IRQ_PRIO[i];
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: owns mepc/mcause/mtval/mie/mstatus.{MIE,MPIE}
// and sequences trap entry, MRET and the fetch-redirect handshake.
module trap_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            exc_valid_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] int_pc_i,
  input  logic [15:0]     irq_i,
  input  logic            csr_we_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic [XLEN-1:0] mtvec_i,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o,
  output logic            mstatus_mie_o,
  output logic            mstatus_mpie_o,
  output logic [15:0]     mie_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  input  logic            redirect_ready_i,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  trap_state_e     r_state;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_redirect_pc;
  logic [15:0]     r_mie_reg;
  logic            r_mie;
  logic            r_mpie;
  logic            r_flush;
  logic            r_redirect_valid;
  logic            r_busy;
  logic            r_is_irq;
  logic [3:0]      r_code;

  logic [15:0]     w_pending;
  logic            w_irq_valid;
  logic [3:0]      w_irq_code;
  logic            w_take_irq;

  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                  input logic            is_irq,
                                                  input logic [3:0]      code);
    logic [XLEN-1:0] base;
    base = {tvec[XLEN-1:2], 2'b00};
    // Only mode 1 vectors, and only for interrupts; modes 2/3 fall back to direct.
    if (is_irq && (tvec[1:0] == 2'b01)) begin
      base = base + {{(XLEN-6){1'b0}}, code, 2'b00};
    end
    return base;
  endfunction

  assign w_pending  = irq_i & r_mie_reg;
  assign w_take_irq = w_irq_valid && r_mie;

  trap_irq_prio u_irq_prio (
    .i_pending (w_pending),
    .o_valid   (w_irq_valid),
    .o_code    (w_irq_code)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= ST_IDLE;
      r_mepc           <= '0;
      r_mcause         <= '0;
      r_mtval          <= '0;
      r_redirect_pc    <= '0;
      r_mie_reg        <= '0;
      r_mie            <= 1'b0;
      r_mpie           <= 1'b0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_busy           <= 1'b0;
      r_is_irq         <= 1'b0;
      r_code           <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Trap sources take precedence over a same-cycle CSR write.
          if (exc_valid_i) begin
            r_mepc   <= exc_pc_i;
            r_mcause <= exc_cause_i;
            r_mtval  <= exc_tval_i;
            r_is_irq <= 1'b0;
            r_code   <= '0;
            r_flush  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_ENTRY;
          end else if (mret_i) begin
            r_flush  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_RETURN;
          end else if (w_take_irq) begin
            r_mepc   <= int_pc_i;
            r_mcause <= {1'b1, {(XLEN-5){1'b0}}, w_irq_code};
            r_mtval  <= '0;
            r_is_irq <= 1'b1;
            r_code   <= w_irq_code;
            r_flush  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_ENTRY;
          end else if (csr_we_i) begin
            case (csr_addr_i)
              CSR_MEPC:    r_mepc    <= {csr_wdata_i[XLEN-1:1], 1'b0};
              CSR_MCAUSE:  r_mcause  <= csr_wdata_i;
              CSR_MTVAL:   r_mtval   <= csr_wdata_i;
              CSR_MIE:     r_mie_reg <= csr_wdata_i[15:0];
              CSR_MSTATUS: begin
                r_mie  <= csr_wdata_i[MSTATUS_MIE_BIT];
                r_mpie <= csr_wdata_i[MSTATUS_MPIE_BIT];
              end
              default: ;
            endcase
          end
        end
        ST_ENTRY: begin
          r_mpie           <= r_mie;
          r_mie            <= 1'b0;
          r_flush          <= 1'b0;
          r_redirect_pc    <= trap_target(mtvec_i, r_is_irq, r_code);
          r_redirect_valid <= 1'b1;
          r_state          <= ST_REDIRECT;
        end
        ST_RETURN: begin
          r_mie            <= r_mpie;
          r_mpie           <= 1'b1;
          r_flush          <= 1'b0;
          r_redirect_pc    <= r_mepc;
          r_redirect_valid <= 1'b1;
          r_state          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (redirect_ready_i) begin
            r_redirect_valid <= 1'b0;
            r_busy           <= 1'b0;
            r_state          <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mepc_o           = r_mepc;
  assign mcause_o         = r_mcause;
  assign mtval_o          = r_mtval;
  assign mstatus_mie_o    = r_mie;
  assign mstatus_mpie_o   = r_mpie;
  assign mie_o            = r_mie_reg;
  assign flush_o          = r_flush;
  assign redirect_valid_o = r_redirect_valid;
  assign redirect_pc_o    = r_redirect_pc;
  assign busy_o           = r_busy;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a queue of expected redirects.
module tb_trap_ctrl;
  import csr_pkg::*;

  localparam int XLEN = 64;
  typedef logic [XLEN-1:0] x_t;

  typedef struct {
    x_t   pc;
    x_t   mepc;
    x_t   mcause;
    x_t   mtval;
    logic mie;
    logic mpie;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        exc_valid_i = 1'b0;
  x_t          exc_cause_i = '0;
  x_t          exc_pc_i = '0;
  x_t          exc_tval_i = '0;
  logic        mret_i = 1'b0;
  x_t          int_pc_i = '0;
  logic [15:0] irq_i = '0;
  logic        csr_we_i = 1'b0;
  logic [11:0] csr_addr_i = '0;
  x_t          csr_wdata_i = '0;
  x_t          mtvec_i = '0;
  x_t          mepc_o, mcause_o, mtval_o, redirect_pc_o;
  logic        mstatus_mie_o, mstatus_mpie_o, flush_o, redirect_valid_o, busy_o;
  logic        redirect_ready_i = 1'b0;
  logic [15:0] mie_o;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .exc_valid_i      (exc_valid_i),
    .exc_cause_i      (exc_cause_i),
    .exc_pc_i         (exc_pc_i),
    .exc_tval_i       (exc_tval_i),
    .mret_i           (mret_i),
    .int_pc_i         (int_pc_i),
    .irq_i            (irq_i),
    .csr_we_i         (csr_we_i),
    .csr_addr_i       (csr_addr_i),
    .csr_wdata_i      (csr_wdata_i),
    .mtvec_i          (mtvec_i),
    .mepc_o           (mepc_o),
    .mcause_o         (mcause_o),
    .mtval_o          (mtval_o),
    .mstatus_mie_o    (mstatus_mie_o),
    .mstatus_mpie_o   (mstatus_mpie_o),
    .mie_o            (mie_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_ready_i (redirect_ready_i),
    .redirect_pc_o    (redirect_pc_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input x_t obs, input x_t exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic csr_write(input logic [11:0] addr, input x_t data);
    csr_we_i    = 1'b1;
    csr_addr_i  = addr;
    csr_wdata_i = data;
    tick();
    csr_we_i    = 1'b0;
  endtask

  // Trap inputs are already driven; measure the IDLE->redirect latency and score the result.
  task automatic wait_redirect(input string tag);
    int   n;
    exp_t e;
    tick();
    n = 1;
    check({tag, "_flush"}, x_t'(flush_o), 1);
    check({tag, "_busy"}, x_t'(busy_o), 1);
    check({tag, "_early_valid"}, x_t'(redirect_valid_o), 0);
    exc_valid_i = 1'b0;
    mret_i      = 1'b0;
    csr_we_i    = 1'b0;
    while (!redirect_valid_o && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, x_t'(n), 2);
    check({tag, "_flush_off"}, x_t'(flush_o), 0);
    check({tag, "_sb_entry"}, x_t'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_pc"}, redirect_pc_o, e.pc);
      check({tag, "_mepc"}, mepc_o, e.mepc);
      check({tag, "_mcause"}, mcause_o, e.mcause);
      check({tag, "_mtval"}, mtval_o, e.mtval);
      check({tag, "_mie"}, x_t'(mstatus_mie_o), x_t'(e.mie));
      check({tag, "_mpie"}, x_t'(mstatus_mpie_o), x_t'(e.mpie));
    end
  endtask

  task automatic handshake(input string tag);
    redirect_ready_i = 1'b1;
    tick();
    redirect_ready_i = 1'b0;
    check({tag, "_hs_valid"}, x_t'(redirect_valid_o), 0);
    check({tag, "_hs_busy"}, x_t'(busy_o), 0);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_busy", x_t'(busy_o), 0);
    check("rst_valid", x_t'(redirect_valid_o), 0);
    check("rst_flush", x_t'(flush_o), 0);
    check("rst_pc", redirect_pc_o, 0);
    check("rst_mepc", mepc_o, 0);
    check("rst_mcause", mcause_o, 0);
    check("rst_mie_reg", x_t'(mie_o), 0);
    check("rst_mstatus", x_t'({mstatus_mpie_o, mstatus_mie_o}), 0);

    // Illegal-instruction exception, direct mtvec
    mtvec_i     = 64'h8000_0100;
    exc_valid_i = 1'b1;
    exc_cause_i = x_t'(CAUSE_ILLEGAL_INST);
    exc_pc_i    = 64'h8000_0010;
    exc_tval_i  = 64'hdead_beef;
    sb.push_back('{pc: 64'h8000_0100, mepc: 64'h8000_0010, mcause: 64'd2,
                   mtval: 64'hdead_beef, mie: 1'b0, mpie: 1'b0});
    wait_redirect("exc_ill");
    handshake("exc_ill");

    // CSR writes, including an unowned address and mepc bit-0 clearing
    csr_write(12'h305, '1);
    check("unowned_mepc", mepc_o, 64'h8000_0010);
    check("unowned_mtval", mtval_o, 64'hdead_beef);
    csr_write(CSR_MTVAL, 64'h55);
    check("csr_mtval", mtval_o, 64'h55);
    csr_write(CSR_MSTATUS, 64'h8);
    csr_write(CSR_MIE, 64'hffff_0888);
    check("csr_mie_reg", x_t'(mie_o), 64'h888);
    check("csr_mstatus_mie", x_t'(mstatus_mie_o), 1);
    check("csr_mstatus_mpie", x_t'(mstatus_mpie_o), 0);

    // MSI beats MTI; vectored mtvec adds 4*code
    mtvec_i  = 64'h8000_0101;
    int_pc_i = 64'h8000_0040;
    irq_i    = 16'h0088;
    sb.push_back('{pc: 64'h8000_010c, mepc: 64'h8000_0040, mcause: {1'b1, 59'd0, 4'd3},
                   mtval: 64'd0, mie: 1'b0, mpie: 1'b1});
    wait_redirect("irq_msi");
    check("irq_msi_mie_reg", x_t'(mie_o), 64'h888);
    irq_i = 16'h0000;
    handshake("irq_msi");

    // MRET to a software-written mepc
    csr_write(CSR_MEPC, 64'h8000_0205);
    check("csr_mepc_bit0", mepc_o, 64'h8000_0204);
    mret_i = 1'b1;
    sb.push_back('{pc: 64'h8000_0204, mepc: 64'h8000_0204, mcause: {1'b1, 59'd0, 4'd3},
                   mtval: 64'd0, mie: 1'b1, mpie: 1'b1});
    wait_redirect("mret");
    handshake("mret");

    // Exception, MTI and a CSR write in one cycle: exception wins, write dropped
    exc_valid_i = 1'b1;
    exc_cause_i = x_t'(CAUSE_ECALL_M);
    exc_pc_i    = 64'h8000_0300;
    exc_tval_i  = 64'hcafe;
    irq_i       = 16'h0080;
    csr_we_i    = 1'b1;
    csr_addr_i  = CSR_MTVAL;
    csr_wdata_i = 64'h1234;
    sb.push_back('{pc: 64'h8000_0100, mepc: 64'h8000_0300, mcause: 64'd11,
                   mtval: 64'hcafe, mie: 1'b0, mpie: 1'b1});
    wait_redirect("exc_vs_mti");
    handshake("exc_vs_mti");
    check("mti_masked_busy", x_t'(busy_o), 0);
    mret_i = 1'b1;
    sb.push_back('{pc: 64'h8000_0300, mepc: 64'h8000_0300, mcause: 64'd11,
                   mtval: 64'hcafe, mie: 1'b1, mpie: 1'b1});
    wait_redirect("mret2");
    int_pc_i = 64'h8000_0304;
    handshake("mret2");
    sb.push_back('{pc: 64'h8000_011c, mepc: 64'h8000_0304, mcause: {1'b1, 59'd0, 4'd7},
                   mtval: 64'd0, mie: 1'b0, mpie: 1'b1});
    wait_redirect("mti");
    irq_i = 16'h0000;
    handshake("mti");

    // Back-pressure: redirect stable for 5 cycles, new traps ignored
    mtvec_i     = 64'h8000_0200;
    exc_valid_i = 1'b1;
    exc_cause_i = x_t'(CAUSE_LOAD_ACCESS);
    exc_pc_i    = 64'h8000_0400;
    exc_tval_i  = 64'h1000;
    sb.push_back('{pc: 64'h8000_0200, mepc: 64'h8000_0400, mcause: 64'd5,
                   mtval: 64'h1000, mie: 1'b0, mpie: 1'b0});
    wait_redirect("stall");
    exc_valid_i = 1'b1;
    exc_pc_i    = 64'h9999_0000;
    mret_i      = 1'b1;
    mtvec_i     = 64'h9000_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", x_t'(redirect_valid_o), 1);
      check("stall_pc", redirect_pc_o, 64'h8000_0200);
    end
    check("stall_mepc", mepc_o, 64'h8000_0400);
    check("stall_mcause", mcause_o, 64'd5);
    exc_valid_i = 1'b0;
    mret_i      = 1'b0;
    handshake("stall");
    check("stall_idle_mepc", mepc_o, 64'h8000_0400);

    // Reset while waiting for the redirect handshake
    mtvec_i     = 64'h8000_0100;
    exc_valid_i = 1'b1;
    exc_cause_i = x_t'(CAUSE_BREAKPOINT);
    exc_pc_i    = 64'h8000_0500;
    exc_tval_i  = 64'h0;
    sb.push_back('{pc: 64'h8000_0100, mepc: 64'h8000_0500, mcause: 64'd3,
                   mtval: 64'h0, mie: 1'b0, mpie: 1'b0});
    wait_redirect("rst_mid");
    rst_i = 1'b1;
    tick();
    check("rstmid_valid", x_t'(redirect_valid_o), 0);
    check("rstmid_busy", x_t'(busy_o), 0);
    check("rstmid_flush", x_t'(flush_o), 0);
    check("rstmid_pc", redirect_pc_o, 0);
    check("rstmid_mepc", mepc_o, 0);
    check("rstmid_mcause", mcause_o, 0);
    check("rstmid_mtval", mtval_o, 0);
    check("rstmid_mie_reg", x_t'(mie_o), 0);
    check("rstmid_mstatus", x_t'({mstatus_mpie_o, mstatus_mie_o}), 0);
    rst_i = 1'b0;
    redirect_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_no_redirect", x_t'(redirect_valid_o), 0);
      check("rstmid_idle", x_t'(busy_o), 0);
    end
    redirect_ready_i = 1'b0;
    check("sb_drained", x_t'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath and CSR width.
REQ-002 SHALL have port clk_i  input  1  the single clock.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port exc_valid_i  input  1  execute stage reports a synchronous exception.
REQ-005 SHALL have port exc_cause_i  input  XLEN  exception code as a csr_mcause_e value with bit XLEN-1 clear.
REQ-006 SHALL have port exc_pc_i  input  XLEN  PC of the faulting instruction.
REQ-007 SHALL have port exc_tval_i  input  XLEN  trap value (bad address or instruction).
REQ-008 SHALL have port mret_i  input  1  an MRET instruction retires.
REQ-009 SHALL have port int_pc_i  input  XLEN  PC of the next instruction, saved on interrupt.
REQ-010 SHALL have port irq_i  input  16  raw mip bits (SSI 1, MSI 3, STI 5, MTI 7, SEI 9, MEI 11, LCOFI 13).
REQ-011 SHALL have port csr_we_i  input  1  CSR write strobe from the CSR unit.
REQ-012 SHALL have port csr_addr_i  input  12  CSR address as a csr_addrs_e value.
REQ-013 SHALL have port csr_wdata_i  input  XLEN  CSR write data.
REQ-014 SHALL have port mtvec_i  input  XLEN  current mtvec value.
REQ-015 SHALL have ports mepc_o, mcause_o, mtval_o  output  XLEN  each  the owned trap CSRs.
REQ-016 SHALL have ports mstatus_mie_o, mstatus_mpie_o  output  1  each  mstatus bits 3 and 7.
REQ-017 SHALL have port mie_o  output  16  the interrupt-enable register.
REQ-018 SHALL have port flush_o  output  1  kills the in-flight pipeline.
REQ-019 SHALL have port redirect_valid_o  output  1  requests a fetch redirect.
REQ-020 SHALL have port redirect_ready_i  input  1  fetch accepts the redirect.
REQ-021 SHALL have port redirect_pc_o  output  XLEN  redirect target.
REQ-022 SHALL have port busy_o  output  1  controller is not IDLE, so issue stalls.

Function
REQ-023 SHALL implement FSM states IDLE, ENTRY, RETURN and REDIRECT.
REQ-024 In IDLE, SHALL select the trap source in priority order: exc_valid_i, then mret_i, then a pending interrupt.
REQ-025 A pending interrupt SHALL mean that (irq_i & mie_o) is nonzero and mstatus_mie_o is 1.
REQ-026 Interrupt priority SHALL be fixed highest-first: MEI, MSI, MTI, SEI, SSI, STI, LCOFI; mcause SHALL be {1'b1, code}.
REQ-027 On an exception, IDLE->ENTRY SHALL latch mepc=exc_pc_i, mcause=exc_cause_i and mtval=exc_tval_i.
REQ-028 On an interrupt, IDLE->ENTRY SHALL latch mepc=int_pc_i, mcause=the interrupt code and mtval=0.
REQ-029 In ENTRY, for one cycle, SHALL set mpie=mie, set mie=0 and assert flush_o, then go to REDIRECT.
REQ-030 The ENTRY target SHALL be {mtvec[XLEN-1:2],2'b00}, plus 4*code when mtvec[1:0]==1 and the trap is an interrupt.
REQ-031 mtvec_i[1:0] values 2 and 3 SHALL be treated as direct mode.
REQ-032 On mret_i, IDLE->RETURN; RETURN SHALL, for one cycle, set mie=mpie, set mpie=1, assert flush_o and target mepc_o.
REQ-033 In REDIRECT, redirect_valid_o SHALL be held with a stable redirect_pc_o until redirect_ready_i.
REQ-034 Transfer SHALL complete on the cycle redirect_valid_o&&redirect_ready_i, and the FSM SHALL return to IDLE the next cycle.
REQ-035 IDLE to redirect_valid_o SHALL take exactly 2 cycles (IDLE->ENTRY/RETURN->REDIRECT).
REQ-036 exc_valid_i, mret_i and interrupts SHALL be ignored outside IDLE; the pipeline is stalled by busy_o.
REQ-037 A CSR write in IDLE to mepc (bit 0 forced to 0), mcause, mtval, mie (low 16 bits) or mstatus (bits 3 and 7) SHALL update the register next cycle.
REQ-038 A CSR write in the same cycle as a trap SHALL be dropped; the trap wins.
REQ-039 Writes to unowned addresses SHALL be ignored.

Reset
REQ-040 On rst_i, SHALL reset state=IDLE, mepc/mcause/mtval=0, mie_o=0, mstatus_mie_o=0 and mstatus_mpie_o=0.
REQ-041 On rst_i, SHALL reset flush_o=0, redirect_valid_o=0, redirect_pc_o=0 and busy_o=0.
REQ-042 Reset asserted mid-trap SHALL abandon the trap with no redirect.

Structure
REQ-043 State enum and interrupt priority table SHALL live in csr_pkg next to csr_addrs_e and csr_mcause_e.
REQ-044 One sub-module, trap_irq_prio, SHALL map the 16-bit pending mask to a valid flag and a 4-bit code.

Verification
REQ-045 Bench SHALL cover: exc IllegalInst, pc=0x80000010, tval=0xdeadbeef, mtvec=0x80000100 -> mepc/mcause/mtval = 0x80000010/2/0xdeadbeef, redirect to 0x80000100 at cycle +2.
REQ-046 Bench SHALL cover: MIE=1, mie=0x888, irq=0x088, mtvec=0x80000101 -> mcause={1,3}, redirect 0x8000010c, mie_o stays 0x888, mstatus_mie_o=0, mstatus_mpie_o=1.
REQ-047 Bench SHALL cover: exception plus pending MTI in the same cycle -> exception taken; after MRET the MTI is taken.
REQ-048 Bench SHALL cover: MRET with mepc=0x80000204 and mpie=1 -> redirect 0x80000204, mstatus_mie_o=1, mstatus_mpie_o=1.
REQ-049 Bench SHALL cover: redirect_ready_i held low 5 cycles -> redirect_valid_o and redirect_pc_o stable, new exc_valid_i ignored.
REQ-050 Bench SHALL cover: rst_i during REDIRECT -> all outputs reset next cycle, no handshake completes.
